mixer_sequencer: RTL and testbench

Initiator for the mixer's load/execute interface. On each sample-rate tick it snapshots two oscillator samples and their levels, then drives the mixer's shared 8-bit sample bus: sample 1 with its load strobe, sample 2 with its load strobe, then a one-cycle execute. It sits between the oscillators and the mixer, one instance per voice.

---
 rtl/mixer_sequencer_pkg.sv | 22 ++
 rtl/mixer_sequencer.sv | 136 +++++++++++++
 tb/tb_mixer_sequencer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/mixer_sequencer_pkg.sv
// Shared definitions for the mixer sequencer: default widths, FSM state codes
// and the level code that means "mute".
package mixer_sequencer_pkg;

    localparam int DEFAULT_SAMPLE_WIDTH = 8;
    localparam int DEFAULT_LEVEL_WIDTH  = 3;
    localparam int DEFAULT_COUNT_WIDTH  = 16;

    localparam int STATE_WIDTH = 3;
    typedef logic [STATE_WIDTH-1:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_SETUP1 = 3'd1;
    localparam state_t ST_LOAD1  = 3'd2;
    localparam state_t ST_SETUP2 = 3'd3;
    localparam state_t ST_LOAD2  = 3'd4;
    localparam state_t ST_EXEC   = 3'd5;

    // All-ones level code silences a channel; any other value is a right-shift amount.
    localparam logic [DEFAULT_LEVEL_WIDTH-1:0] LEVEL_MUTE = '1;

endpackage

// File: rtl/mixer_sequencer.sv
// Per-voice initiator for the mixer: on an accepted sample tick it snapshots both
// oscillators and plays them onto the shared bus as load1, load2, then execute.
module mixer_sequencer
    import mixer_sequencer_pkg::*;
#(
    parameter int SAMPLE_WIDTH = DEFAULT_SAMPLE_WIDTH,
    parameter int LEVEL_WIDTH  = DEFAULT_LEVEL_WIDTH,
    parameter int COUNT_WIDTH  = DEFAULT_COUNT_WIDTH
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_sample_tick,
    input  logic [SAMPLE_WIDTH-1:0] i_osc_1_sample,
    input  logic [SAMPLE_WIDTH-1:0] i_osc_2_sample,
    input  logic [LEVEL_WIDTH-1:0]  i_osc_1_level,
    input  logic [LEVEL_WIDTH-1:0]  i_osc_2_level,
    output logic [SAMPLE_WIDTH-1:0] o_sample,
    output logic                    o_sample_1_load,
    output logic                    o_sample_2_load,
    output logic [LEVEL_WIDTH-1:0]  o_sample_1_level,
    output logic [LEVEL_WIDTH-1:0]  o_sample_2_level,
    output logic                    o_execute,
    output logic                    o_busy,
    output logic                    o_overrun,
    output logic [COUNT_WIDTH-1:0]  o_frame_count,
    output state_t                  o_debug_state
);

    // Mixer handshake: the mixer captures o_sample on any cycle its load strobe is
    // high and mixes on o_execute; it never stalls, so there is no ready signal.

    state_t state_q;
    state_t state_d;

    logic                    tick_live;
    logic                    accept;
    logic [SAMPLE_WIDTH-1:0] snap_2_q;

    logic [SAMPLE_WIDTH-1:0] sample_d;
    logic [SAMPLE_WIDTH-1:0] snap_2_d;
    logic [LEVEL_WIDTH-1:0]  level_1_d;
    logic [LEVEL_WIDTH-1:0]  level_2_d;
    logic                    load_1_d;
    logic                    load_2_d;
    logic                    execute_d;
    logic                    busy_d;
    logic                    overrun_d;
    logic [COUNT_WIDTH-1:0]  count_d;

    assign tick_live     = i_sample_tick & i_enable;
    assign accept        = tick_live && (state_q == ST_IDLE);
    assign o_debug_state = state_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (accept) state_d = ST_SETUP1;
            ST_SETUP1: state_d = ST_LOAD1;
            ST_LOAD1:  state_d = ST_SETUP2;
            ST_SETUP2: state_d = ST_LOAD2;
            ST_LOAD2:  state_d = ST_EXEC;
            ST_EXEC:   state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Next values for the registered outputs; the bus and levels hold unless updated.
    always_comb begin
        sample_d  = o_sample;
        snap_2_d  = snap_2_q;
        level_1_d = o_sample_1_level;
        level_2_d = o_sample_2_level;
        load_1_d  = 1'b0;
        load_2_d  = 1'b0;
        execute_d = 1'b0;
        busy_d    = o_busy;
        overrun_d = o_overrun | (tick_live && (state_q != ST_IDLE));
        count_d   = o_frame_count;
        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    sample_d  = i_osc_1_sample;
                    snap_2_d  = i_osc_2_sample;
                    level_1_d = i_osc_1_level;
                    level_2_d = i_osc_2_level;
                    busy_d    = 1'b1;
                end
            end
            ST_SETUP1: load_1_d = 1'b1;
            ST_LOAD1:  sample_d = snap_2_q;
            ST_SETUP2: load_2_d = 1'b1;
            ST_LOAD2: begin
                execute_d = 1'b1;
                count_d   = o_frame_count + 1'b1;
            end
            ST_EXEC:   busy_d = 1'b0;
            default:   busy_d = 1'b0;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_sample         <= '0;
            snap_2_q         <= '0;
            o_sample_1_level <= {LEVEL_WIDTH{1'b1}};
            o_sample_2_level <= {LEVEL_WIDTH{1'b1}};
            o_sample_1_load  <= 1'b0;
            o_sample_2_load  <= 1'b0;
            o_execute        <= 1'b0;
            o_busy           <= 1'b0;
            o_overrun        <= 1'b0;
            o_frame_count    <= '0;
        end else begin
            o_sample         <= sample_d;
            snap_2_q         <= snap_2_d;
            o_sample_1_level <= level_1_d;
            o_sample_2_level <= level_2_d;
            o_sample_1_load  <= load_1_d;
            o_sample_2_load  <= load_2_d;
            o_execute        <= execute_d;
            o_busy           <= busy_d;
            o_overrun        <= overrun_d;
            o_frame_count    <= count_d;
        end
    end

endmodule

// File: tb/tb_mixer_sequencer.sv
// Bench for mixer_sequencer: a time-since-tick model checked every cycle, a tiny
// mixer model fed from the bus, and directed frames with hand-computed values.
module tb_mixer_sequencer;
    import mixer_sequencer_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b0;
    logic       tick = 1'b0;
    logic [7:0] osc_1 = '0;
    logic [7:0] osc_2 = '0;
    logic [2:0] lvl_1 = '0;
    logic [2:0] lvl_2 = '0;

    logic [7:0]  o_sample;
    logic        o_load_1, o_load_2, o_execute, o_busy, o_overrun;
    logic [2:0]  o_lvl_1, o_lvl_2;
    logic [15:0] o_count;
    state_t      o_state;

    logic [7:0] w_sample;
    logic       w_load_1, w_load_2, w_execute, w_busy, w_overrun;
    logic [2:0] w_lvl_1, w_lvl_2;
    logic [1:0] w_count;
    state_t     w_state;

    int checks = 0;
    int errors = 0;
    bit checking = 0;

    always #5 clk = ~clk;

    mixer_sequencer dut (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_sample_tick(tick),
        .i_osc_1_sample(osc_1), .i_osc_2_sample(osc_2),
        .i_osc_1_level(lvl_1), .i_osc_2_level(lvl_2),
        .o_sample(o_sample), .o_sample_1_load(o_load_1), .o_sample_2_load(o_load_2),
        .o_sample_1_level(o_lvl_1), .o_sample_2_level(o_lvl_2),
        .o_execute(o_execute), .o_busy(o_busy), .o_overrun(o_overrun),
        .o_frame_count(o_count), .o_debug_state(o_state)
    );

    mixer_sequencer #(.COUNT_WIDTH(2)) dut_w (
        .i_clock(clk), .i_reset(rst), .i_enable(en), .i_sample_tick(tick),
        .i_osc_1_sample(osc_1), .i_osc_2_sample(osc_2),
        .i_osc_1_level(lvl_1), .i_osc_2_level(lvl_2),
        .o_sample(w_sample), .o_sample_1_load(w_load_1), .o_sample_2_load(w_load_2),
        .o_sample_1_level(w_lvl_1), .o_sample_2_level(w_lvl_2),
        .o_execute(w_execute), .o_busy(w_busy), .o_overrun(w_overrun),
        .o_frame_count(w_count), .o_debug_state(w_state)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a frame is described only by how many edges have passed since its tick.
    bit         m_busy = 0;
    int         m_age = 0;
    logic [7:0] m_sample = '0;
    logic [7:0] m_snap_2 = '0;
    logic [2:0] m_lvl_1 = LEVEL_MUTE;
    logic [2:0] m_lvl_2 = LEVEL_MUTE;
    int         m_count = 0;
    bit         m_overrun = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy = 0; m_age = 0; m_sample = '0; m_snap_2 = '0;
            m_lvl_1 = LEVEL_MUTE; m_lvl_2 = LEVEL_MUTE; m_count = 0; m_overrun = 0;
        end else if (m_busy) begin
            if (en && tick) m_overrun = 1;
            m_age++;
            if (m_age == 2) m_sample = m_snap_2;
            if (m_age == 4) m_count++;
            if (m_age == 5) m_busy = 0;
        end else if (en && tick) begin
            m_busy = 1; m_age = 0;
            m_sample = osc_1; m_snap_2 = osc_2;
            m_lvl_1 = lvl_1; m_lvl_2 = lvl_2;
        end
    end

    // Mixer stand-in driven from the bus, plus strobe tallies.
    logic [7:0] mx_s1 = '0, mx_s2 = '0;
    logic [2:0] mx_l1 = '0, mx_l2 = '0;
    int mix_out = -1;
    int exec_seen = 0;
    int strobes_seen = 0;

    function automatic int scaled(input logic [7:0] s, input logic [2:0] l);
        return (l == LEVEL_MUTE) ? 0 : int'(s >> l);
    endfunction

    always @(negedge clk) begin
        if (o_load_1) begin mx_s1 = o_sample; mx_l1 = o_lvl_1; end
        if (o_load_2) begin mx_s2 = o_sample; mx_l2 = o_lvl_2; end
        if (o_execute) mix_out = scaled(mx_s1, mx_l1) + scaled(mx_s2, mx_l2);
        exec_seen += int'(o_execute);
        strobes_seen += int'(o_load_1) + int'(o_load_2) + int'(o_execute);
    end

    always @(negedge clk) begin
        if (checking) begin
            check("sample", o_sample, m_sample);
            check("load_1", o_load_1, m_busy && m_age == 1);
            check("load_2", o_load_2, m_busy && m_age == 3);
            check("execute", o_execute, m_busy && m_age == 4);
            check("level_1", o_lvl_1, m_lvl_1);
            check("level_2", o_lvl_2, m_lvl_2);
            check("busy", o_busy, m_busy);
            check("overrun", o_overrun, m_overrun);
            check("frame_count", o_count, m_count % 65536);
            check("strobe_mutex", (int'(o_load_1) + int'(o_load_2) + int'(o_execute)) <= 1, 1);
            check("w_frame_count", w_count, m_count % 4);
            check("w_overrun", w_overrun, m_overrun);
            check("w_busy", w_busy, m_busy);
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives a tick so the next edge (edge N) samples it; returns 1ns after edge N.
    task automatic pulse_tick(input logic [7:0] s1, input logic [7:0] s2,
                              input logic [2:0] l1, input logic [2:0] l2);
        osc_1 = s1; osc_2 = s2; lvl_1 = l1; lvl_2 = l2;
        en = 1'b1; tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    int wrap_exp[5] = '{1, 2, 3, 0, 1};
    int e0, s0;

    initial begin
        step(1);
        checking = 1;
        check("reset_sample", o_sample, 0);
        check("reset_level_1", o_lvl_1, 7);
        check("reset_busy", o_busy, 0);
        do_reset();

        // Basic frame: 60 then 80 at full level.
        pulse_tick(8'd60, 8'd80, 3'd0, 3'd0);
        check("basic_n0_sample", o_sample, 60);
        check("basic_n0_busy", o_busy, 1);
        step(1);
        check("basic_n1_load_1", o_load_1, 1);
        check("basic_n1_sample", o_sample, 60);
        step(1);
        check("basic_n2_sample", o_sample, 80);
        check("basic_n2_load_1", o_load_1, 0);
        step(1);
        check("basic_n3_load_2", o_load_2, 1);
        step(1);
        check("basic_n4_execute", o_execute, 1);
        check("basic_n4_count", o_count, 1);
        step(1);
        check("basic_n5_execute", o_execute, 0);
        check("basic_n5_busy", o_busy, 0);
        check("basic_mix", mix_out, 140);

        // Level snapshot: input changes after the tick must not leak in.
        step(1);
        pulse_tick(8'd60, 8'd80, 3'd7, 3'd0);
        step(1);
        lvl_1 = 3'd0; lvl_2 = 3'd1; osc_1 = 8'hff; osc_2 = 8'h11;
        step(1);
        check("snap_n2_sample", o_sample, 80);
        step(2);
        check("snap_n4_level_1", o_lvl_1, 7);
        check("snap_n4_level_2", o_lvl_2, 0);
        check("snap_n4_execute", o_execute, 1);
        step(1);
        check("snap_mix", mix_out, 80);

        // Enable gating: ticks with enable low do nothing.
        s0 = strobes_seen;
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            step(1);
            tick = 1'b0;
            step(9);
        end
        check("gate_strobes", strobes_seen - s0, 0);
        check("gate_count", o_count, 2);
        check("gate_overrun", o_overrun, 0);

        // Overrun: second tick lands at edge N+3, third at N+6 is accepted.
        e0 = exec_seen;
        pulse_tick(8'd10, 8'd20, 3'd1, 3'd2);
        check("ovr_n0_overrun", o_overrun, 0);
        step(2);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("ovr_n3_overrun", o_overrun, 1);
        step(2);
        check("ovr_one_execute", exec_seen - e0, 1);
        tick = 1'b1;
        step(1);
        tick = 1'b0;
        check("ovr_n6_busy", o_busy, 1);
        check("ovr_n6_overrun", o_overrun, 1);
        step(5);
        check("ovr_count", o_count, 4);

        // Reset between load1 and load2 takes effect without a clock edge.
        pulse_tick(8'd33, 8'd44, 3'd2, 3'd3);
        step(2);
        #2 rst = 1'b1;
        #1;
        check("rst_sample", o_sample, 0);
        check("rst_load_2", o_load_2, 0);
        check("rst_execute", o_execute, 0);
        check("rst_level_1", o_lvl_1, 7);
        check("rst_level_2", o_lvl_2, 7);
        check("rst_busy", o_busy, 0);
        check("rst_overrun", o_overrun, 0);
        check("rst_count", o_count, 0);
        @(negedge clk);
        rst = 1'b0;
        step(1);
        pulse_tick(8'd90, 8'd91, 3'd0, 3'd0);
        step(3);
        check("rst_clean_load_2", o_load_2, 1);
        check("rst_clean_sample", o_sample, 91);
        step(1);
        check("rst_clean_count", o_count, 1);
        step(1);

        // Counter wrap on the 2-bit instance: back-to-back frames six edges apart.
        do_reset();
        for (int k = 0; k < 5; k++) begin
            pulse_tick(8'(k * 3), 8'(k * 5), 3'd0, 3'd1);
            step(4);
            check("wrap_count", w_count, wrap_exp[k]);
            step(1);
        end
        check("wrap_overrun", w_overrun, 0);
        check("wrap_main_count", o_count, 5);
        step(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
